// File: rtl/ysyx_220053_pkg.sv
// Shared decode definitions for the NPC core: base opcodes, the immediate
// format encoding (ExtOp) and the registered control bundle.
package ysyx_220053_pkg;

  // RV32I / RV64I base opcodes
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;

  // Immediate format selector shared with the execute stage
  typedef enum logic [2:0] {
    EXT_I = 3'd0,
    EXT_U = 3'd1,
    EXT_S = 3'd2,
    EXT_B = 3'd3,
    EXT_J = 3'd4,
    EXT_R = 3'd5
  } ext_op_e;

  // Decoded control bundle carried to execute
  typedef struct packed {
    ext_op_e    ext_op;
    logic       alu_src_b;
    logic       wen;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       illegal;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } ctrl_t;

endpackage

// File: rtl/ysyx_220053_imm_gen.sv
// Immediate generator: assembles the immediate for the selected format and
// sign-extends bit 31 up to XLEN. Format R yields zero.
// Ports:
//   i_ext_op  immediate format
//   i_instr   32-bit instruction word
//   o_imm     XLEN-wide sign-extended immediate
module ysyx_220053_imm_gen
  import ysyx_220053_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  ext_op_e           i_ext_op,
  input  logic [31:0]       i_instr,
  output logic [XLEN-1:0]   o_imm
);

  logic [31:0] w_imm32;
  logic        w_unused_opc;

  // Opcode bits never contribute to any immediate
  assign w_unused_opc = ^i_instr[6:0];

  always_comb begin
    w_imm32 = '0;
    case (i_ext_op)
      EXT_I:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
      EXT_U:   w_imm32 = {i_instr[31:12], 12'b0};
      EXT_S:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      EXT_B:   w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                          i_instr[30:25], i_instr[11:8], 1'b0};
      EXT_J:   w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                          i_instr[20], i_instr[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end

  // Every 32-bit form already carries bit 31 as its sign; widen signed
  assign o_imm = XLEN'($signed(w_imm32));

endmodule

// File: rtl/ysyx_220053_decode_stage.sv
// Registered instruction-decode stage: decodes RV32I/RV64I base opcodes into a
// control bundle plus immediate, flags illegal encodings and latches ebreak
// into a sticky halt. Valid/ready handshake on both sides, flush from branch
// resolution.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   in_valid/in_ready            fetch handshake; in_instr, in_pc payload
//   flush                        kill the registered bundle and current offer
//   out_valid/out_ready          execute handshake
//   out_pc, out_imm, out_ext_op  registered PC, immediate and its format
//   out_alu_src_b, out_wen       operand-B select, register write
//   out_rd, out_rs1, out_rs2     register indices
//   out_mem_read/_write, out_branch, out_jump, out_illegal  class flags
//   halt                         sticky, set by an accepted ebreak
module ysyx_220053_decode_stage
  import ysyx_220053_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter bit          EN_MEMOPS = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_ext_op,
  output logic            out_alu_src_b,
  output logic            out_wen,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            out_branch,
  output logic            out_jump,
  output logic            out_illegal,
  output logic            halt
);

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic            w_shamt_lo_ok;
  logic            w_shamt_hi_ok;
  logic            w_op_f7_ok;
  logic            w_ill;
  logic            w_ebreak;
  logic            w_accept;
  ctrl_t           w_ctrl;
  logic [XLEN-1:0] w_imm;

  ctrl_t           r_ctrl;
  logic [XLEN-1:0] r_imm;
  logic [XLEN-1:0] r_pc;
  logic            r_valid;
  logic            r_halt;

  assign w_opcode = in_instr[6:0];
  assign w_funct3 = in_instr[14:12];
  assign w_funct7 = in_instr[31:25];

  // R-type funct7: 0x00 always, 0x20 only for SUB/SRA
  assign w_op_f7_ok = (w_funct7 == 7'h00) ||
                      ((w_funct7 == 7'h20) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)));

  // Immediate shifts: on RV64 bit 25 belongs to the 6-bit shamt
  always_comb begin
    w_shamt_lo_ok = 1'b0;
    w_shamt_hi_ok = 1'b0;
    if (XLEN == 64) begin
      w_shamt_lo_ok = (in_instr[31:26] == 6'b000000);
      w_shamt_hi_ok = (in_instr[31:26] == 6'b010000);
    end else begin
      w_shamt_lo_ok = (w_funct7 == 7'h00);
      w_shamt_hi_ok = (w_funct7 == 7'h20);
    end
  end

  // Opcode decode into the control bundle
  always_comb begin
    w_ctrl        = '0;
    w_ctrl.ext_op = EXT_I;
    w_ctrl.rd     = in_instr[11:7];
    w_ctrl.rs1    = in_instr[19:15];
    w_ctrl.rs2    = in_instr[24:20];
    w_ill         = 1'b0;
    w_ebreak      = 1'b0;
    case (w_opcode)
      OPC_LUI, OPC_AUIPC: begin
        w_ctrl.ext_op    = EXT_U;
        w_ctrl.alu_src_b = 1'b1;
        w_ctrl.wen       = 1'b1;
      end
      OPC_OP_IMM: begin
        w_ctrl.alu_src_b = 1'b1;
        w_ctrl.wen       = 1'b1;
        if ((w_funct3 == 3'b001) || (w_funct3 == 3'b101))
          w_ill = !(w_shamt_lo_ok || w_shamt_hi_ok);
      end
      OPC_OP: begin
        w_ctrl.ext_op = EXT_R;
        w_ctrl.wen    = 1'b1;
        w_ill         = !w_op_f7_ok;
      end
      OPC_LOAD: begin
        w_ctrl.mem_read  = 1'b1;
        w_ctrl.wen       = 1'b1;
        w_ctrl.alu_src_b = 1'b1;
        w_ill            = !EN_MEMOPS;
      end
      OPC_STORE: begin
        w_ctrl.ext_op    = EXT_S;
        w_ctrl.mem_write = 1'b1;
        w_ill            = !EN_MEMOPS;
      end
      OPC_BRANCH: begin
        w_ctrl.ext_op = EXT_B;
        w_ctrl.branch = 1'b1;
        w_ill         = (w_funct3[2:1] == 2'b01);
      end
      OPC_JAL: begin
        w_ctrl.ext_op = EXT_J;
        w_ctrl.jump   = 1'b1;
        w_ctrl.wen    = 1'b1;
      end
      OPC_JALR: begin
        w_ctrl.jump = 1'b1;
        w_ctrl.wen  = 1'b1;
        w_ill       = (w_funct3 != 3'b000);
      end
      OPC_SYSTEM: begin
        if (in_instr == INSTR_EBREAK) w_ebreak = 1'b1;
        else if (in_instr != INSTR_ECALL) w_ill = 1'b1;
      end
      OPC_OP_IMM_32: begin
        w_ctrl.alu_src_b = 1'b1;
        w_ctrl.wen       = 1'b1;
        w_ill            = (XLEN != 64);
      end
      OPC_OP_32: begin
        w_ctrl.ext_op = EXT_R;
        w_ctrl.wen    = 1'b1;
        w_ill         = (XLEN != 64) || !w_op_f7_ok;
      end
      default: w_ill = 1'b1;
    endcase
    // Illegal encodings flow downstream with no side effects
    if (w_ill) begin
      w_ctrl.wen       = 1'b0;
      w_ctrl.mem_read  = 1'b0;
      w_ctrl.mem_write = 1'b0;
      w_ctrl.branch    = 1'b0;
      w_ctrl.jump      = 1'b0;
      w_ebreak         = 1'b0;
    end
    w_ctrl.illegal = w_ill;
  end

  ysyx_220053_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .i_ext_op (w_ctrl.ext_op),
    .i_instr  (in_instr),
    .o_imm    (w_imm)
  );

  assign in_ready = !r_halt && (!r_valid || out_ready);
  assign w_accept = in_valid && in_ready && !flush;

  // Pipeline register: rst > flush > load > consume/hold
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_halt  <= 1'b0;
      r_ctrl  <= '0;
      r_imm   <= '0;
      r_pc    <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_ctrl  <= w_ctrl;
      r_imm   <= w_imm;
      r_pc    <= in_pc;
      if (w_ebreak) r_halt <= 1'b1;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid     = r_valid;
  assign halt          = r_halt;
  assign out_pc        = r_pc;
  assign out_imm       = r_imm;
  assign out_ext_op    = r_ctrl.ext_op;
  assign out_alu_src_b = r_ctrl.alu_src_b;
  assign out_wen       = r_ctrl.wen;
  assign out_rd        = r_ctrl.rd;
  assign out_rs1       = r_ctrl.rs1;
  assign out_rs2       = r_ctrl.rs2;
  assign out_mem_read  = r_ctrl.mem_read;
  assign out_mem_write = r_ctrl.mem_write;
  assign out_branch    = r_ctrl.branch;
  assign out_jump      = r_ctrl.jump;
  assign out_illegal   = r_ctrl.illegal;

endmodule

// File: tb/tb_ysyx_220053_decode_stage.sv
// Bench for the decode stage: RV64 instance driven through a scoreboard,
// plus an RV32 / no-memops instance for width- and option-dependent decode.
module tb_ysyx_220053_decode_stage;

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] imm;
    logic [2:0]  ext;
    logic        asb, wen, mr, mw, br, jp, ill, chk;
  } vec_t;

  typedef struct {
    vec_t        v;
    logic [63:0] pc;
  } sb_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // RV64 instance
  logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc, out_pc, out_imm;
  logic [2:0]  out_ext_op;
  logic        out_alu_src_b, out_wen, out_mem_read, out_mem_write;
  logic        out_branch, out_jump, out_illegal, halt;
  logic [4:0]  out_rd, out_rs1, out_rs2;

  ysyx_220053_decode_stage #(.XLEN(64), .EN_MEMOPS(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_imm(out_imm), .out_ext_op(out_ext_op), .out_alu_src_b(out_alu_src_b),
    .out_wen(out_wen), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .out_branch(out_branch), .out_jump(out_jump), .out_illegal(out_illegal),
    .halt(halt)
  );

  // RV32 instance without memory ops
  logic        b_rst, b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
  logic [31:0] b_in_instr, b_in_pc, b_out_pc, b_out_imm;
  logic [2:0]  b_out_ext_op;
  logic        b_asb, b_wen, b_mr, b_mw, b_br, b_jp, b_ill, b_halt;
  logic [4:0]  b_rd, b_rs1, b_rs2;

  ysyx_220053_decode_stage #(.XLEN(32), .EN_MEMOPS(1'b0)) dut32 (
    .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_instr(b_in_instr), .in_pc(b_in_pc), .flush(b_flush),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_pc(b_out_pc),
    .out_imm(b_out_imm), .out_ext_op(b_out_ext_op), .out_alu_src_b(b_asb),
    .out_wen(b_wen), .out_rd(b_rd), .out_rs1(b_rs1), .out_rs2(b_rs2),
    .out_mem_read(b_mr), .out_mem_write(b_mw), .out_branch(b_br),
    .out_jump(b_jp), .out_illegal(b_ill), .halt(b_halt)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  sb_t  sb[$];
  vec_t tbl[$];
  vec_t cur;
  bit   m_valid = 1'b0;
  bit   m_halt  = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // flags = {alu_src_b, wen, mem_read, mem_write, branch, jump, illegal}
  function automatic vec_t mk(input logic [31:0] instr, input logic [63:0] imm,
                              input logic [2:0] ext, input logic [6:0] flags);
    vec_t v;
    v.instr = instr; v.imm = imm; v.ext = ext;
    {v.asb, v.wen, v.mr, v.mw, v.br, v.jp, v.ill} = flags;
    v.chk = !flags[0];
    return v;
  endfunction

  task automatic cmp_bundle(input sb_t e);
    logic [31:0] ins;
    ins = e.v.instr;
    check("pc", out_pc, e.pc);
    if (e.v.chk) begin
      check("imm", out_imm, e.v.imm);
      check("ext_op", 64'(out_ext_op), 64'(e.v.ext));
      check("alu_src_b", 64'(out_alu_src_b), 64'(e.v.asb));
    end
    check("wen", 64'(out_wen), 64'(e.v.wen));
    check("mem_read", 64'(out_mem_read), 64'(e.v.mr));
    check("mem_write", 64'(out_mem_write), 64'(e.v.mw));
    check("branch", 64'(out_branch), 64'(e.v.br));
    check("jump", 64'(out_jump), 64'(e.v.jp));
    check("illegal", 64'(out_illegal), 64'(e.v.ill));
    check("rd", 64'(out_rd), 64'(ins[11:7]));
    check("rs1", 64'(out_rs1), 64'(ins[19:15]));
    check("rs2", 64'(out_rs2), 64'(ins[24:20]));
  endtask

  task automatic offer(input vec_t v, input logic [63:0] pc);
    cur = v; in_instr = v.instr; in_pc = pc; in_valid = 1'b1;
  endtask

  // One clock: check at negedge, advance the model at posedge, return accept
  task automatic cycle(output bit acc);
    bit exp_ready, cons;
    @(negedge clk);
    exp_ready = !m_halt && (!m_valid || out_ready);
    check("in_ready", 64'(in_ready), 64'(exp_ready));
    check("out_valid", 64'(out_valid), 64'(m_valid));
    check("halt", 64'(halt), 64'(m_halt));
    if (m_valid && sb.size() != 0) cmp_bundle(sb[0]);
    acc  = !rst && !flush && in_valid && exp_ready;
    cons = m_valid && out_ready;
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0; m_halt = 1'b0; sb.delete();
    end else if (flush) begin
      m_valid = 1'b0; sb.delete();
    end else begin
      if (cons) begin sb.delete(0); m_valid = 1'b0; end
      if (acc) begin
        sb.push_back('{v: cur, pc: in_pc});
        m_valid = 1'b1;
        if (cur.instr == EBREAK) m_halt = 1'b1;
      end
    end
    #1;
  endtask

  initial begin
    bit   acc;
    int   idx, guard;
    vec_t addi, sw, add, ebrk;

    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b1;
    b_rst = 1'b1; b_in_valid = 1'b0; b_in_instr = '0; b_in_pc = '0; b_flush = 1'b0; b_out_ready = 1'b1;

    tbl.push_back(mk(32'h00500093, 64'd5, 3'd0, 7'b1100000));
    tbl.push_back(mk(32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 7'b1100000));
    tbl.push_back(mk(32'h12345137, 64'h1234_5000, 3'd1, 7'b1100000));
    tbl.push_back(mk(32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 7'b0000100));
    tbl.push_back(mk(32'h0020A423, 64'd8, 3'd2, 7'b0001000));
    tbl.push_back(mk(32'h008000EF, 64'd8, 3'd4, 7'b0100010));
    tbl.push_back(mk(32'h00008067, 64'd0, 3'd0, 7'b0100010));
    tbl.push_back(mk(32'h002081B3, 64'd0, 3'd5, 7'b0100000));
    tbl.push_back(mk(32'h402081B3, 64'd0, 3'd5, 7'b0100000));
    tbl.push_back(mk(32'h022081B3, 64'd0, 3'd5, 7'b0000001));
    tbl.push_back(mk(32'h4210D093, 64'h421, 3'd0, 7'b1100000));
    tbl.push_back(mk(32'h00000073, 64'd0, 3'd0, 7'b0000000));
    tbl.push_back(mk(32'hFFFFFFFF, 64'd0, 3'd0, 7'b0000001));
    tbl.push_back(mk(32'h0040A283, 64'd4, 3'd0, 7'b1110000));
    tbl.push_back(mk(32'h80000197, 64'hFFFF_FFFF_8000_0000, 3'd1, 7'b1100000));
    tbl.push_back(mk(32'h00002063, 64'd0, 3'd0, 7'b0000001));
    tbl.push_back(mk(32'h0010009B, 64'd1, 3'd0, 7'b1100000));
    tbl.push_back(mk(32'h00009067, 64'd0, 3'd0, 7'b0000001));
    tbl.push_back(mk(32'h80001013, 64'd0, 3'd0, 7'b0000001));

    addi = tbl[0];
    sw   = tbl[4];
    add  = tbl[7];
    ebrk = mk(EBREAK, 64'd1, 3'd0, 7'b0000000);

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_halt", 64'(halt), 64'd0);
    check("rst_imm", out_imm, 64'd0);
    check("rst_pc", out_pc, 64'd0);
    check("rst_ext_op", 64'(out_ext_op), 64'd0);
    check("rst_flags", 64'({out_wen, out_mem_read, out_mem_write, out_branch,
                            out_jump, out_illegal, out_alu_src_b}), 64'd0);
    check("rst_idx", 64'({out_rd, out_rs1, out_rs2}), 64'd0);
    rst = 1'b0;
    cycle(acc);

    // Stream the table with random back-pressure
    idx = 0; guard = 0;
    while (idx < tbl.size() && guard < 500) begin
      offer(tbl[idx], 64'h8000_0000 + 64'(idx) * 4);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle(acc);
      if (acc) idx++;
      guard++;
    end
    check("stream_done", 64'(idx), 64'(tbl.size()));
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) cycle(acc);

    // Store held three cycles behind a stalled consumer
    offer(sw, 64'h100); out_ready = 1'b0;
    cycle(acc);
    check("sw_accept", 64'(acc), 64'd1);
    offer(add, 64'h104);
    repeat (3) cycle(acc);
    out_ready = 1'b1;
    cycle(acc);
    check("add_accept_on_consume", 64'(acc), 64'd1);

    // Flush with a held bundle and an offered ebreak, then flush on an open stage
    offer(ebrk, 64'h108); out_ready = 1'b0; flush = 1'b1;
    cycle(acc);
    out_ready = 1'b1;
    cycle(acc);
    flush = 1'b0; in_valid = 1'b0;
    cycle(acc);
    check("halt_after_flush", 64'(halt), 64'd0);

    // ebreak halts; addi stays blocked; reset discards the held bundle
    offer(ebrk, 64'h200); out_ready = 1'b0;
    cycle(acc);
    check("ebreak_accept", 64'(acc), 64'd1);
    offer(addi, 64'h204);
    repeat (10) cycle(acc);
    rst = 1'b1;
    cycle(acc);
    rst = 1'b0; out_ready = 1'b1;
    cycle(acc);
    check("addi_after_reset", 64'(acc), 64'd1);
    in_valid = 1'b0;
    repeat (2) cycle(acc);

    // RV32, memory ops disabled
    @(negedge clk);
    b_rst = 1'b0; b_in_valid = 1'b1;
    b_in_instr = 32'h0010009B;
    @(negedge clk);
    check("rv32_addiw_valid", 64'(b_out_valid), 64'd1);
    check("rv32_addiw_illegal", 64'(b_ill), 64'd1);
    check("rv32_addiw_flags", 64'({b_wen, b_mr, b_mw, b_br, b_jp}), 64'd0);
    b_in_instr = 32'hFFFFFFFF;
    @(negedge clk);
    check("rv32_ones_illegal", 64'(b_ill), 64'd1);
    check("rv32_ones_flags", 64'({b_wen, b_mr, b_mw, b_br, b_jp}), 64'd0);
    b_in_instr = 32'h0040A283;
    @(negedge clk);
    check("rv32_lw_nomem_illegal", 64'(b_ill), 64'd1);
    check("rv32_lw_nomem_read", 64'(b_mr), 64'd0);
    b_in_instr = 32'h4210D093;
    @(negedge clk);
    check("rv32_srai_shamt6_illegal", 64'(b_ill), 64'd1);
    b_in_instr = 32'hFFF00093;
    @(negedge clk);
    check("rv32_addi_legal", 64'(b_ill), 64'd0);
    check("rv32_addi_imm", 64'(b_out_imm), 64'h0000_0000_FFFF_FFFF);
    check("rv32_addi_wen", 64'(b_wen), 64'd1);
    b_in_valid = 1'b0;
    @(negedge clk);
    check("rv32_drained", 64'(b_out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ysyx_220053_decode_stage.md
# ysyx_220053_decode_stage

Registered instruction-decode stage for the NPC core. It replaces the single-cycle combinational controller with a parametrised pipeline stage. It decodes the RV32I/RV64I base opcodes into a control bundle plus a sign-extended immediate, flags illegal encodings, and latches `ebreak` into a sticky halt. It sits between the fetch stage and the execute stage, with valid/ready handshakes on both sides and a flush input from branch resolution.

## Interface
Parameters:
- `XLEN`, 32: datapath width, 32 or 64. The W-ops are legal only when 64.
- `EN_MEMOPS`, 1: when 0, LOAD/STORE decode as illegal.

Ports:
- `clk`  in  1  clock, single domain.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  fetch offers an instruction.
- `in_ready`  out  1  stage accepts this cycle.
- `in_instr`  in  32  instruction word.
- `in_pc`  in  XLEN  instruction address.
- `flush`  in  1  kill the registered instruction and drop the current offer.
- `out_valid`  out  1  decoded bundle valid.
- `out_ready`  in  1  execute consumes the bundle.
- `out_pc`  out  XLEN  registered PC.
- `out_imm`  out  XLEN  sign-extended immediate.
- `out_ext_op`  out  3  immediate format (I/U/S/B/J/R).
- `out_alu_src_b`  out  1  1 selects imm, 0 selects rs2.
- `out_wen`  out  1  register-file write.
- `out_rd`, `out_rs1`, `out_rs2`  out  5 each  register indices.
- `out_mem_read`, `out_mem_write`, `out_branch`, `out_jump`  out  1 each  class flags.
- `out_illegal`  out  1  unrecognised encoding.
- `halt`  out  1  sticky, set by an accepted `ebreak`.

## Operation
- Decode is combinational on `in_instr`. The result is loaded into the output register on accept: `in_valid && in_ready && !flush`.

Decode rules:
- LUI and AUIPC: format U. `alu_src_b=1`, `wen=1`.
- OP-IMM: format I. `alu_src_b=1`, `wen=1`.
  - SLLI/SRLI/SRAI: funct7 legal only if it is 0x00 or 0x20 in the top bits. Shamt width is 5 bits (XLEN 32) or 6 bits (XLEN 64).
- OP: format R. `alu_src_b=0`, `wen=1`. funct7 must be 0x00, or 0x20 for SUB/SRA.
- LOAD: format I. `mem_read=1`, `wen=1`, `alu_src_b=1`.
- STORE: format S. `mem_write=1`, `wen=0`.
- BRANCH: format B. `branch=1`, `wen=0`. funct3 values 2 and 3 are illegal.
- JAL: format J. `jump=1`, `wen=1`.
- JALR: format I. `jump=1`, `wen=1`. funct3 must be 0.
- SYSTEM:
  - 0x00100073 (`ebreak`) sets `halt` when accepted.
  - 0x00000073 (`ecall`) is decoded as a no-op with `wen=0`.
  - All other SYSTEM encodings are illegal.
- OP-IMM-32 and OP-32: legal only when XLEN==64. Formats are I and R respectively.

Illegal handling:
- `out_illegal=1` and all write/memory/branch/jump flags are forced to 0.
- The stage does not stall; an illegal instruction flows downstream like any other.

Immediates:
- The immediate is assembled per format with bit 31 replicated up to XLEN.
- Format R gives `imm=0`.
- U immediates sign-extend bit 31 in RV64.

## Timing
- Latency: exactly 1 cycle from accept to `out_valid`.
- `in_ready = !halt && (!out_valid || out_ready)`.
- Register update priority: `rst` > `flush` > load > hold.
  - `flush` clears `out_valid` on the next edge, regardless of `out_ready`. `halt` is not cleared by flush.
  - On hold (`out_valid && !out_ready`), every output is stable.
- `halt` rises on the edge that accepts the `ebreak`. On that same edge `out_valid` rises carrying the `ebreak` bundle. From the following cycle `in_ready=0`. Halt releases only on `rst`.
- `ebreak` dropped by a simultaneous `flush` does not set `halt`.
- Reset values: `out_valid=0`, `halt=0`, all control flags 0, `out_imm=0`, `out_pc=0`, indices 0, `out_ext_op=I(0)`.
- `rst` asserted mid-operation discards the registered bundle. `in_ready` is 1 in the first cycle after reset release.

## Structure
- Shared package `ysyx_220053_pkg` holds:
  - opcode constants;
  - ExtOp encodings I=0, U=1, S=2, B=3, J=4, R=5;
  - the decoded control-bundle typedef.
- One sub-module, `ysyx_220053_imm_gen` (combinational; ext_op + instr → XLEN imm), reused later by the execute stage.
- Decode logic and the pipeline register live in the top module.

## Test plan
- `addi x1,x0,5` (0x00500093), XLEN=64 → one cycle later `out_valid=1`, `ext_op=0`, `imm=5`, `alu_src_b=1`, `wen=1`, `rd=1`.
  - Repeat with 0xFFF00093 → `imm=0xFFFF_FFFF_FFFF_FFFF`.
- `lui x2,0x12345` (0x12345137) and `beq x0,x0,-4` (0xFE000EE3):
  - lui → `ext_op=1`, `imm=0x12345000`, `rd=2`.
  - beq → `ext_op=3`, `imm=-4`, `branch=1`, `wen=0`.
- `sw x2,8(x1)` (0x0020A423) held with `out_ready=0` for 3 cycles:
  - bundle stable, `in_ready=0`, `imm=8`, `mem_write=1`, `wen=0`;
  - consumed on the 4th cycle with no loss or duplication.
- `ebreak` (0x00100073) followed by `addi`:
  - `halt=1` from the cycle after accept;
  - `in_ready` stays 0 for 10 cycles with the `addi` still offered;
  - `rst` pulse clears `halt` and `out_valid`.
- 0xFFFFFFFF, and `addiw` (0x0010009B) at XLEN=32 → `out_illegal=1`, with `wen`, `mem_*`, `branch`, `jump` all 0.
- `flush` asserted together with an offered `ebreak` while a bundle is held → next cycle `out_valid=0`, `halt=0`.
